// File: rtl/load_store_unit.sv
// Load/store unit: one data-memory access per request on a req/gnt/rvalid port, with load extension and writeback.
// Latency: store done 2 cycles after start; load writeback strobe 3 cycles after start (zero-wait memory).
// Backpressure: holds o_mem_req until i_mem_gnt and stalls the pipeline via o_busy. Build option: LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
    parameter int NB_WORD = 32,
    parameter int NB_ADDR = 32,
    parameter int NB_REG  = 5
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic               i_dmem_rd,
    input  logic               i_dmem_wr,
    input  logic [2:0]         i_ld_st_funct3,
    input  logic [NB_REG-1:0]  i_rd,
    input  logic [NB_ADDR-1:0] i_addr,
    input  logic [NB_WORD-1:0] i_wdata,
    output logic               o_busy,
    output logic               o_mem_req,
    output logic               o_mem_we,
    output logic [NB_ADDR-1:0] o_mem_addr,
    output logic [3:0]         o_mem_be,
    output logic [NB_WORD-1:0] o_mem_wdata,
    input  logic               i_mem_gnt,
    input  logic               i_mem_rvalid,
    input  logic [NB_WORD-1:0] i_mem_rdata,
    output logic               o_wb_valid,
    output logic [NB_REG-1:0]  o_wb_rd,
    output logic [NB_WORD-1:0] o_wb_data,
    output logic               o_misaligned
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

    state_t state, state_nxt;

    logic               req_any;
    logic               legal;
    logic               start;
    logic [3:0]         be_nxt;
    logic [NB_WORD-1:0] wdata_nxt;

    logic [2:0]         f3_q;
    logic [1:0]         a_lo_q;
    logic [NB_REG-1:0]  rd_q;

    logic [1:0]         rd_off;
    logic [NB_WORD-1:0] lane;
    logic [NB_WORD-1:0] ext_data;

    assign req_any = i_dmem_rd | i_dmem_wr;

    // Store wins when both strobes are set, so legality follows the store table then.
    always_comb begin
        legal = 1'b0;
        case (i_ld_st_funct3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = ~i_dmem_wr;
            default:                legal = 1'b0;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic misal;
    logic misal_q;

    always_comb begin
        misal = 1'b0;
        case (i_ld_st_funct3[1:0])
            2'b01:   misal = i_addr[0];
            2'b10:   misal = (i_addr[1:0] != 2'b00);
            default: misal = 1'b0;
        endcase
    end

    assign start = (state == IDLE) & req_any & legal & ~misal;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            misal_q <= 1'b0;
        end else begin
            misal_q <= (state == IDLE) & req_any & legal & misal;
        end
    end

    assign o_misaligned = misal_q;
`else
    assign start        = (state == IDLE) & req_any & legal;
    assign o_misaligned = 1'b0;
`endif

    // Lane select and replication; half ignores a[0] and word ignores a[1:0].
    always_comb begin
        be_nxt    = 4'b1111;
        wdata_nxt = i_wdata;
        case (i_ld_st_funct3[1:0])
            2'b00: begin
                be_nxt    = 4'b0001 << i_addr[1:0];
                wdata_nxt = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                be_nxt    = 4'b0011 << {i_addr[1], 1'b0};
                wdata_nxt = {2{i_wdata[15:0]}};
            end
            default: begin
                be_nxt    = 4'b1111;
                wdata_nxt = i_wdata;
            end
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = REQ;
            REQ:     if (i_mem_gnt) state_nxt = o_mem_we ? IDLE : WAIT_R;
            WAIT_R:  if (i_mem_rvalid) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_be    <= 4'b0000;
            o_mem_wdata <= '0;
            f3_q        <= 3'b000;
            a_lo_q      <= 2'b00;
            rd_q        <= '0;
        end else if (start) begin
            o_mem_we    <= i_dmem_wr;
            o_mem_addr  <= {i_addr[NB_ADDR-1:2], 2'b00};
            o_mem_be    <= be_nxt;
            o_mem_wdata <= wdata_nxt;
            f3_q        <= i_ld_st_funct3;
            a_lo_q      <= i_addr[1:0];
            rd_q        <= i_rd;
        end
    end

    always_comb begin
        rd_off = 2'b00;
        case (f3_q[1:0])
            2'b00:   rd_off = a_lo_q;
            2'b01:   rd_off = {a_lo_q[1], 1'b0};
            default: rd_off = 2'b00;
        endcase
    end

    assign lane = i_mem_rdata >> {rd_off, 3'b000};

    always_comb begin
        ext_data = lane;
        case (f3_q)
            3'b000:  ext_data = {{(NB_WORD-8){lane[7]}}, lane[7:0]};
            3'b100:  ext_data = {{(NB_WORD-8){1'b0}}, lane[7:0]};
            3'b001:  ext_data = {{(NB_WORD-16){lane[15]}}, lane[15:0]};
            3'b101:  ext_data = {{(NB_WORD-16){1'b0}}, lane[15:0]};
            default: ext_data = lane;
        endcase
    end

    // Result is held after the strobe until the next load captures.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_wb_rd   <= '0;
            o_wb_data <= '0;
        end else if ((state == WAIT_R) && i_mem_rvalid) begin
            o_wb_rd   <= rd_q;
            o_wb_data <= ext_data;
        end
    end

    assign o_mem_req  = (state == REQ);
    assign o_wb_valid = (state == DONE);
    assign o_busy     = start | (state == REQ) | (state == WAIT_R);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: expected memory requests and writebacks are queued, a monitor compares them.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        dmem_rd;
    logic        dmem_wr;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misaligned;

    load_store_unit dut (
        .i_clock        (clk),
        .i_reset_n      (rst_n),
        .i_dmem_rd      (dmem_rd),
        .i_dmem_wr      (dmem_wr),
        .i_ld_st_funct3 (funct3),
        .i_rd           (rd),
        .i_addr         (addr),
        .i_wdata        (wdata),
        .o_busy         (busy),
        .o_mem_req      (mem_req),
        .o_mem_we       (mem_we),
        .o_mem_addr     (mem_addr),
        .o_mem_be       (mem_be),
        .o_mem_wdata    (mem_wdata),
        .i_mem_gnt      (mem_gnt),
        .i_mem_rvalid   (mem_rvalid),
        .i_mem_rdata    (mem_rdata),
        .o_wb_valid     (wb_valid),
        .o_wb_rd        (wb_rd),
        .o_wb_data      (wb_data),
        .o_misaligned   (misaligned)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    req_t req_q[$];
    wb_t  wb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: every granted request and every writeback strobe must match the head of its queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_req && mem_gnt) begin
                if (req_q.size() == 0) begin
                    check("unexpected_req", 32'd1, 32'd0);
                end else begin
                    req_t e;
                    e = req_q.pop_front();
                    check("req_we", {31'd0, mem_we}, {31'd0, e.we});
                    check("req_addr", mem_addr, e.addr);
                    check("req_be", {28'd0, mem_be}, {28'd0, e.be});
                    check("req_wdata", mem_wdata, e.wdata);
                end
            end
            if (wb_valid) begin
                if (wb_q.size() == 0) begin
                    check("unexpected_wb", 32'd1, 32'd0);
                end else begin
                    wb_t w;
                    w = wb_q.pop_front();
                    check("wb_rd", {27'd0, wb_rd}, {27'd0, w.rd});
                    check("wb_data", wb_data, w.data);
                end
            end
        end
    end

    task automatic drive(input logic r, input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d, input logic [4:0] rdr);
        dmem_rd = r;
        dmem_wr = w;
        funct3  = f3;
        addr    = a;
        wdata   = d;
        rd      = rdr;
    endtask

    task automatic push_req(input logic we, input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        req_t e;
        e.we = we; e.addr = a; e.be = be; e.wdata = d;
        req_q.push_back(e);
    endtask

    task automatic push_wb(input logic [4:0] r, input logic [31:0] d);
        wb_t w;
        w.rd = r; w.data = d;
        wb_q.push_back(w);
    endtask

    // Start in cycle N, hold gnt low for gdly cycles checking the request is stable, then grant.
    task automatic start_and_grant(input logic r, input logic w, input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] d, input logic [4:0] rdr, input int gdly,
                                   input logic [31:0] ea, input logic [3:0] ebe);
        @(posedge clk); #1;
        drive(r, w, f3, a, d, rdr);
        @(negedge clk);
        check("busy_at_start", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
        for (int i = 0; i < gdly; i++) begin
            @(negedge clk);
            check("req_held", {31'd0, mem_req}, 32'd1);
            check("addr_stable", mem_addr, ea);
            check("be_stable", {28'd0, mem_be}, {28'd0, ebe});
            @(posedge clk); #1;
        end
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
    endtask

    task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] ea, input logic [3:0] ebe, input logic [31:0] ed);
        push_req(1'b1, ea, ebe, ed);
        start_and_grant(1'b0, 1'b1, f3, a, d, 5'd0, 0, ea, ebe);
        @(negedge clk);
        check("busy_after_store", {31'd0, busy}, 32'd0);
    endtask

    task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] rdr,
                           input int gdly, input logic [31:0] rdata, input logic [31:0] ea,
                           input logic [3:0] ebe, input logic [31:0] edata);
        push_req(1'b0, ea, ebe, 32'h0);
        push_wb(rdr, edata);
        start_and_grant(1'b1, 1'b0, f3, a, 32'h0, rdr, gdly, ea, ebe);
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        @(negedge clk);
        check("busy_wait_r", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        @(negedge clk);
        check("wb_valid_n3", {31'd0, wb_valid}, 32'd1);
        check("busy_in_done", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("wb_valid_one_cycle", {31'd0, wb_valid}, 32'd0);
        check("wb_data_held", wb_data, edata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_wb_data", wb_data, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // SB to byte 3 of word 0x100
        do_store(3'b000, 32'h103, 32'h0000_00A5, 32'h100, 4'b1000, 32'hA5A5_A5A5);
        // SH to upper half
        do_store(3'b001, 32'h102, 32'h1234_ABCD, 32'h100, 4'b1100, 32'hABCD_ABCD);

        // LB / LBU from byte 2
        do_load(3'b000, 32'h202, 5'd7, 0, 32'h0080_FF00, 32'h200, 4'b0100, 32'hFFFF_FF80);
        do_load(3'b100, 32'h202, 5'd7, 0, 32'h0080_FF00, 32'h200, 4'b0100, 32'h0000_0080);
        // LH with 3-cycle grant delay
        do_load(3'b001, 32'h102, 5'd3, 3, 32'h8001_1234, 32'h100, 4'b1100, 32'hFFFF_8001);
        // LHU from lower half
        do_load(3'b101, 32'h100, 5'd12, 0, 32'h0000_F00D, 32'h100, 4'b0011, 32'h0000_F00D);

        // Both strobes set: store wins, single write, no writeback
        push_req(1'b1, 32'h40, 4'b1111, 32'hDEAD_BEEF);
        start_and_grant(1'b1, 1'b1, 3'b010, 32'h40, 32'hDEAD_BEEF, 5'd2, 0, 32'h40, 4'b1111);
        @(negedge clk);
        check("sw_busy_done", {31'd0, busy}, 32'd0);
        check("sw_no_wb", {31'd0, wb_valid}, 32'd0);

        // Illegal funct3 issues nothing
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 3'b011, 32'h80, 32'h0, 5'd1);
        @(negedge clk);
        check("illegal_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        check("illegal_no_req", {31'd0, mem_req}, 32'd0);

        // Stray gnt/rvalid in IDLE are ignored
        @(posedge clk); #1;
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
        @(negedge clk);
        check("stray_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        @(negedge clk);
        check("stray_no_wb", {31'd0, wb_valid}, 32'd0);
        check("stray_no_req", {31'd0, mem_req}, 32'd0);

        // Reset while waiting for read data; late rvalid must be dropped
        push_req(1'b0, 32'h80, 4'b1111, 32'h0);
        start_and_grant(1'b1, 1'b0, 3'b010, 32'h80, 32'h0, 5'd9, 0, 32'h80, 4'b1111);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_req", {31'd0, mem_req}, 32'd0);
        check("midrst_we", {31'd0, mem_we}, 32'd0);
        check("midrst_addr", mem_addr, 32'h0);
        check("midrst_be", {28'd0, mem_be}, 32'd0);
        check("midrst_wdata", mem_wdata, 32'h0);
        check("midrst_wb_rd", {27'd0, wb_rd}, 32'd0);
        check("midrst_wb_data", wb_data, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("late_rvalid_no_wb", {31'd0, wb_valid}, 32'd0);
            @(posedge clk); #1;
        end

        // Misaligned word load
`ifdef LSU_MISALIGN_TRAP_EN
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 3'b010, 32'h42, 32'h0, 5'd4);
        @(negedge clk);
        check("misal_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        check("misal_pulse", {31'd0, misaligned}, 32'd1);
        check("misal_no_req", {31'd0, mem_req}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("misal_pulse_end", {31'd0, misaligned}, 32'd0);
        check("misal_no_req2", {31'd0, mem_req}, 32'd0);
`else
        do_load(3'b010, 32'h42, 5'd4, 0, 32'h1234_5678, 32'h40, 4'b1111, 32'h1234_5678);
        check("no_misal", {31'd0, misaligned}, 32'd0);
`endif

        repeat (2) @(posedge clk);
        check("req_queue_empty", req_q.size(), 32'd0);
        check("wb_queue_empty", wb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
